// File: rtl/iic_pkg.sv
// Shared types for the IIC bit controller: command encoding, FSM state
// and the per-phase bus level table.
package iic_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Returns {scl,sda} for a command in a given quarter-bit phase.
    function automatic logic [1:0] bus_lvl(cmd_t c, logic [1:0] ph, logic d);
        logic [7:0] t;
        case (c)
            CMD_START: t = 8'b11_11_10_00;
            CMD_STOP:  t = 8'b00_10_11_11;
            CMD_WRITE: t = {1'b0, d, 1'b1, d, 1'b1, d, 1'b0, d};
            default:   t = 8'b01_11_11_01;
        endcase
        return t[{~ph, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/iic_bit_ctrl_if.sv
// Command handshake bundle between the byte layer and the bit controller.
// master issues commands, slave executes them.
interface iic_bit_ctrl_if;
    import iic_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    cmd_t cmd;
    logic din;
    logic dout;
    logic done;

    modport master (
        output cmd_valid, cmd, din,
        input  cmd_ready, dout, done
    );

    modport slave (
        input  cmd_valid, cmd, din,
        output cmd_ready, dout, done
    );

endinterface

// File: rtl/iic_sync.sv
// Multi-flop level synchroniser with configurable depth and reset value.
module iic_sync #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {DEPTH{RST_VAL}};
        end else begin
            ff <= {ff[DEPTH-2:0], d};
        end
    end

    assign q = ff[DEPTH-1];

endmodule

// File: rtl/iic_bit_ctrl.sv
// IIC bit-level controller: START/STOP/WRITE/READ in four tick phases.
// Define IIC_CLK_STRETCH_EN to honour slave clock stretching on scl_i.
module iic_bit_ctrl
    import iic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    iic_bit_ctrl_if.slave  cif,
    input  logic           scl_i,
    input  logic           sda_i,
    output logic           scl_o,
    output logic           sda_o
);

    state_t     state;
    logic [1:0] phase;
    cmd_t       cmd_q;
    logic       din_q;
    logic       dout_q;
    logic       done_q;
    logic       sda_s;
    logic       hold;
    logic       accept;
    logic       step;
    logic       step_mid;
    logic       step_last;
    logic [1:0] lvl_acc;
    logic [1:0] lvl_nxt;

    iic_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sda_i),
        .q     (sda_s)
    );

`ifdef IIC_CLK_STRETCH_EN
    logic scl_s;

    iic_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (scl_i),
        .q     (scl_s)
    );

    // A slave holding scl low freezes the high half of the bit.
    assign hold = (phase == 2'd1 || phase == 2'd2) && !scl_s;
`else
    logic unused_scl;

    assign unused_scl = scl_i;
    assign hold       = 1'b0;
`endif

    assign cif.cmd_ready = (state == ST_IDLE);
    assign cif.dout      = dout_q;
    assign cif.done      = done_q;

    assign accept    = cif.cmd_valid && (state == ST_IDLE);
    assign step      = (state == ST_BUSY) && tick && !hold;
    assign step_last = step && (phase == 2'd3);
    assign step_mid  = step && (phase != 2'd3);

    assign lvl_acc = bus_lvl(cif.cmd, 2'd0, cif.din);
    assign lvl_nxt = bus_lvl(cmd_q, phase + 2'd1, din_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            phase  <= 2'd0;
            cmd_q  <= CMD_START;
            din_q  <= 1'b0;
            dout_q <= 1'b0;
            done_q <= 1'b0;
            scl_o  <= 1'b1;
            sda_o  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (1'b1)
                accept: begin
                    state          <= ST_BUSY;
                    phase          <= 2'd0;
                    cmd_q          <= cif.cmd;
                    din_q          <= cif.din;
                    {scl_o, sda_o} <= lvl_acc;
                end
                step_mid: begin
                    phase          <= phase + 2'd1;
                    {scl_o, sda_o} <= lvl_nxt;
                    if (cmd_q == CMD_READ && phase == 2'd2) begin
                        dout_q <= sda_s;
                    end
                end
                step_last: begin
                    state  <= ST_IDLE;
                    phase  <= 2'd0;
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/iic_bit_ctrl.md
IIC_BIT_CTRL -- requirements
Module: iic_bit_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on scl_i and sda_i (legal 2..4).
REQ-002 SHALL have port clk, input, 1, sole clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tick, input, 1, quarter-bit strobe from the upstream divider carry-out (one clk wide).
REQ-005 SHALL have port cmd_valid, input, 1, command request.
REQ-006 SHALL have port cmd_ready, output, 1, block idle and able to accept.
REQ-007 SHALL have port cmd, input, 2, command (cmd_t).
REQ-008 SHALL have port din, input, 1, bit to transmit for WRITE.
REQ-009 SHALL have port dout, output, 1, last bit received by READ.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have ports scl_i and sda_i, input, 1 each, raw bus levels.
REQ-012 SHALL have ports scl_o and sda_o, output, 1 each, open-drain drive levels (1 = released).

Function
REQ-013 SHALL implement states IDLE and BUSY plus a 2-bit phase counter; cmd_ready = (state==IDLE).
REQ-014 SHALL accept on cmd_valid && cmd_ready, latching cmd and din, entering BUSY with phase 0, and driving phase-0 levels from the next edge.
REQ-015 SHALL advance phase only on tick while in BUSY; a tick in the accept cycle is ignored.
REQ-016 SHALL drive per phase 0/1/2/3 (scl,sda): START 11/11/10/00; STOP 00/10/11/11; WRITE 0d/1d/1d/0d with d=latched din; READ 01/11/11/01.
REQ-017 SHALL register scl_o/sda_o (no combinational path from inputs).
REQ-018 SHALL, for READ, load dout from synchronised sda_i on the tick that ends phase 2; dout holds otherwise.
REQ-019 SHALL, on tick in phase 3, pulse done for exactly one cycle and return to IDLE on the same edge; cmd_ready rises the following cycle.
REQ-020 SHALL hold scl_o/sda_o at their last driven values while IDLE.
REQ-021 SHALL not lose a request presented while BUSY; it is accepted once cmd_ready is high.
REQ-022 SHALL complete every command in exactly 4 accepted ticks when stretching is absent.

Reset
REQ-023 SHALL on rst_n low, asynchronously: state IDLE, phase 0, scl_o=1, sda_o=1, dout=0, done=0, synchronisers to 1.
REQ-024 SHALL abort any in-flight command on reset with no done pulse.

Configuration
REQ-025 SHALL, with IIC_CLK_STRETCH_EN defined, ignore tick in phases 1 and 2 while synchronised scl_i is 0 (slave stretching).
REQ-026 SHALL, without IIC_CLK_STRETCH_EN, ignore scl_i entirely and instantiate no scl_i synchroniser.

Structure
REQ-027 SHALL take cmd_t (CMD_START=0, CMD_STOP=1, CMD_WRITE=2, CMD_READ=3) and the state enum from shared package iic_pkg.
REQ-028 SHALL use sub-module iic_sync (parameterised depth, reset value 1) for each synchronised input.

Verification
REQ-029 SHALL verify: tick every 4 clk, START from reset -> sda_o falls after 2nd tick, scl_o falls after 3rd, done after 4th, scl_o=0 sda_o=0 in IDLE.
REQ-030 SHALL verify: WRITE din=1 -> sda_o=1 all phases, scl_o sequence 0,1,1,0, done once; din change after accept has no effect.
REQ-031 SHALL verify: READ with sda_i=0 at phase 2 -> dout=0; READ with sda_i=1 -> dout=1; dout stable between commands.
REQ-032 SHALL verify: cmd_valid held for two commands back-to-back -> cmd_ready low during BUSY, second accepted the cycle after done's following cycle, none lost.
REQ-033 SHALL verify: with IIC_CLK_STRETCH_EN, scl_i held 0 for 20 clk during WRITE phase 1 -> done delayed by at least 20 clk; without macro, done timing unchanged.
REQ-034 SHALL verify: rst_n asserted mid-WRITE phase 2 -> scl_o=1, sda_o=1 immediately, no done, cmd_ready=1 after release.
